serial_deframer: RTL
====================

# serial_deframer

Downstream consumer of the SerDes serial output. It takes the single-bit stream (`d_out`/`valid_o`/`ready_i` of the SerDes top) on a per-bit valid/ready handshake and hunts for a sync word at any bit alignment. It then extracts fixed-length payload frames of parity-protected bytes and presents them on a one-deep byte valid/ready output. Status outputs and counters feed the link-monitor logic.

## Interface
- `SYNC_WORD`, 8'hA5: frame sync pattern, MSB-first.
- `PAYLOAD_LEN`, 4: payload bytes per frame, legal range 1..255.
- `pclk_i` input 1: single clock; all logic on rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `data_i` input 1: serial bit in.
- `valid_i` input 1: `data_i` valid.
- `ready_o` output 1: bit accepted when `valid_i && ready_o`.
- `data_o` output 8: payload byte.
- `valid_o` output 1: `data_o`, `last_o` and `par_err_o` are valid.
- `ready_i` input 1: byte consumed when `valid_o && ready_i`.
- `last_o` output 1: byte is the final byte of its frame.
- `par_err_o` output 1: byte failed even parity.
- `lock_o` output 1: high when the state is not HUNT.
- `frame_cnt_o` output 16: completed frames; wraps 0xFFFF→0.
- `err_cnt_o` output 8: parity-error bytes; saturates at 255.

## Operation
- **Frame format:** SYNC_WORD (8 bits), then PAYLOAD_LEN × {8 data bits MSB-first, 1 even-parity bit}.
- **Bit handling:** bits advance state only on accept (`valid_i && ready_o`). Idle cycles change nothing.
- **States:** HUNT, DATA, PARITY.
- **HUNT:**
  - Sliding window `win = {win[6:0], data_i}` on each accept.
  - `hcnt` counts accepted bits, saturating at 8.
  - On an accept where `hcnt>=7` and the new window equals SYNC_WORD: go to DATA; clear `bit_cnt` and `byte_cnt`.
  - Matching is at any alignment. Junk or partial sync bits before the word are tolerated.
- **DATA:**
  - Shift the accepted bit into `sh` MSB-first; `bit_cnt++`.
  - On the 8th bit, go to PARITY.
  - Sync patterns inside the payload are ignored.
- **PARITY:**
  - Error when `^sh ^ data_i == 1`.
  - On accept, load the output register: `data_o=sh`, `par_err_o`=error, `last_o=(byte_cnt==PAYLOAD_LEN-1)`, `valid_o=1`.
  - If the byte has an error and `err_cnt_o<255`, increment `err_cnt_o`.
  - If `last_o`: `frame_cnt_o++`, clear `hcnt`, go to HUNT. Otherwise `byte_cnt++`, `bit_cnt=0`, go to DATA.
- **Ready rule:** `ready_o = (state!=PARITY) || !valid_o || ready_i`, combinational.
  - Backpressure stalls only the parity bit.
  - DATA bits keep streaming into `sh` while the output is held.
- **Output register:**
  - `valid_o` clears on consume unless a new load happens in the same cycle.
  - A simultaneous consume and load replaces the contents; no bubble, no loss.
- `lock_o` is combinational from state.

## Timing
- **Reset values:** state HUNT, `win`/`hcnt`/`sh`/`bit_cnt`/`byte_cnt` 0, `data_o` 0, `valid_o` 0, `last_o` 0, `par_err_o` 0, `lock_o` 0, `frame_cnt_o` 0, `err_cnt_o` 0, `ready_o` 1.
- **Reset mid-operation:** a partial frame is discarded and a held output byte is dropped. The block restarts in HUNT and needs a fresh sync.
- **Lock:** `lock_o` rises the cycle after the final sync bit is accepted.
- **Output latency:** `valid_o` rises the cycle after the parity-bit accept.
- **Counters:** update in the same edge as the `valid_o` load.
- **Throughput:** minimum frame is 8+9·PAYLOAD_LEN accepted bits. At full rate, one byte every 9 cycles.
- **`last_o` frame followed by sync:** the next sync may begin the cycle after the parity-bit accept. `hcnt` restarts, so 8 new bits are required.
- **Stability:** `data_o`, `last_o` and `par_err_o` stay stable while `valid_o && !ready_i`.

## Test plan
- **Reset:** assert `rst_i`=0 mid-clock. Required: every output at its reset value asynchronously, `ready_o`=1. Release and send idle. Required: no output activity.
- **Basic frame:**
  - Stimulus: junk bits 1,0,1, then 0xA5, then bytes/parity 0x01/1, 0x22/0, 0x37/1, 0xFF/0, with `ready_i`=1 throughout.
  - Required: four bytes in order with `par_err_o`=0, `last_o` only on 0xFF.
  - Required: `frame_cnt_o`=1, `err_cnt_o`=0, `lock_o` returns to 0 after the last parity bit.
- **Parity error:** same frame, but 0x22 sent with parity bit 1. Required: `par_err_o`=1 on 0x22 only, `err_cnt_o`=1, frame still completes and `frame_cnt_o`=1.
- **Backpressure:**
  - Stimulus: `ready_i`=0 from the first byte onward.
  - Required: byte 0x01 held stable; the byte-2 bits are accepted; `ready_o`=0 at the byte-2 parity bit.
  - Release `ready_i`. Required: 0x22 loads in the consume cycle; all four bytes are delivered with no loss.
- **Reset mid-frame:** assert reset after 2 payload bytes. Required: counters 0 and HUNT. A following full frame is received correctly with `frame_cnt_o`=1.
- **Counter limits:**
  - Send 256 frames each containing a parity error. Required: `err_cnt_o` saturates at 255.
  - Force-load, or run, 65536 frames. Required: `frame_cnt_o` wraps to 0.

Source files
------------

// File: rtl/serial_deframer_if.sv
// Bit-in / byte-out handshake bundle for serial_deframer.
// The slave modport is the deframer's view and the master modport is the source/sink side.
interface serial_deframer_if;
  logic       data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       last_o;
  logic       par_err_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, last_o, par_err_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, last_o, par_err_o
  );
endinterface

// File: rtl/serial_deframer.sv
// Hunts for a sync word at any bit offset, then extracts parity-protected payload bytes
// into a one-deep output register. It also keeps frame and parity-error counters.
module serial_deframer #(
  parameter logic [7:0]  SYNC_WORD   = 8'hA5,
  parameter int unsigned PAYLOAD_LEN = 4
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  serial_deframer_if.slave   bus,
  output logic               lock_o,
  output logic [15:0]        frame_cnt_o,
  output logic [7:0]         err_cnt_o
);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] win, sh, byte_cnt;
  logic [3:0] hcnt, bit_cnt;
  logic [7:0] data_q;
  logic       valid_q, last_q, perr_q;
  logic       ready, accept, consume, load;
  logic       sync_hit, byte_last, par_bad;
  logic [7:0] win_nxt;

  // Only the parity bit is stalled by a held output byte.
  // Payload bits keep shifting into sh while the byte waits.
  assign ready     = (state != PARITY) || !valid_q || bus.ready_i;
  assign accept    = bus.valid_i && ready;
  assign consume   = valid_q && bus.ready_i;
  assign load      = (state == PARITY) && accept;
  assign win_nxt   = {win[6:0], bus.data_i};
  assign sync_hit  = (state == HUNT) && accept && (hcnt >= 4'd7) && (win_nxt == SYNC_WORD);
  assign byte_last = (byte_cnt == LAST_IDX);
  assign par_bad   = (^sh) ^ bus.data_i;

  assign bus.ready_o   = ready;
  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.last_o    = last_q;
  assign bus.par_err_o = perr_q;
  assign lock_o        = (state != HUNT);

  always_ff @(posedge pclk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_i) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through this block leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      HUNT:    if (sync_hit) state_nxt = DATA;
      DATA:    if (accept && bit_cnt == 4'd7) state_nxt = PARITY;
      PARITY:  if (accept) state_nxt = byte_last ? HUNT : DATA;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge pclk_i or negedge rst_i) begin
    if (!rst_i) begin
      win         <= '0;
      hcnt        <= '0;
      sh          <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      perr_q      <= 1'b0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (accept) begin
        unique case (state)
          HUNT: begin
            win  <= win_nxt;
            hcnt <= (hcnt == 4'd8) ? 4'd8 : hcnt + 4'd1;
            if (sync_hit) begin
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
          DATA: begin
            sh      <= {sh[6:0], bus.data_i};
            bit_cnt <= bit_cnt + 4'd1;
          end
          PARITY: begin
            if (byte_last) begin
              hcnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              bit_cnt  <= '0;
            end
          end
          default: ;
        endcase
      end

      // A load in the same cycle as a consume replaces the byte without a bubble.
      if (load) begin
        data_q  <= sh;
        perr_q  <= par_bad;
        last_q  <= byte_last;
        valid_q <= 1'b1;
        if (par_bad && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        if (byte_last) frame_cnt_o <= frame_cnt_o + 16'd1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
